// File: rtl/fifo_rd_packer_if.sv
// Output word bus of the FIFO read-side byte packer: valid/ready handshake with
// lane keep mask and last flag.
interface fifo_rd_packer_if #(
  parameter int DW    = 8,
  parameter int BYTES = 4
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DW*BYTES-1:0]   m_data;
  logic [BYTES-1:0]      m_keep;
  logic                  m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_keep,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_keep,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops bytes from a first-word-fall-through FIFO and packs BYTES of them
// little-endian into words; a flush closes the current partial word early.
module fifo_rd_packer #(
  parameter int DW    = 8,
  parameter int BYTES = 4
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic              rempty,
  input  logic [DW-1:0]     rdata,
  output logic              rinc,
  input  logic              flush,
  output logic              busy,
  fifo_rd_packer_if.master  m
);

  localparam int CW = $clog2(BYTES + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BYTES);

  typedef enum logic {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   m_valid_q;
  logic [DW*BYTES-1:0]    m_data_q;
  logic [BYTES-1:0]       m_keep_q;
  logic                   m_last_q;

  logic [DW*BYTES-1:0]    pack_data_d;
  logic [BYTES-1:0]       pack_keep_d;
  logic                   out_free;
  logic                   xfer;
  logic                   pop;

  assign out_free = !m_valid_q || m.m_ready;
  assign xfer     = out_free &&
                    ((cnt_q == CNT_FULL) || ((state_q == FLUSH) && (cnt_q != '0)));
  // A full accumulator may still pop when the same edge moves it to the output.
  assign pop      = !rrst && !rempty && (state_q == FILL) &&
                    ((cnt_q < CNT_FULL) || xfer);
  assign rinc     = pop;
  assign busy     = (cnt_q != '0) || m_valid_q || (state_q == FLUSH);

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      logic [DW-1:0] lane_q;
      logic          lane_we;

      // After an xfer the accumulator restarts, so a coincident pop goes to lane 0.
      assign lane_we = pop && (xfer ? (gi == 0) : (cnt_q == CW'(gi)));

      always_ff @(posedge rclk) begin
        if (rrst) begin
          lane_q <= '0;
        end else if (lane_we) begin
          lane_q <= rdata;
        end
      end

      assign pack_keep_d[gi]            = (CW'(gi) < cnt_q);
      assign pack_data_d[gi*DW +: DW]   = pack_keep_d[gi] ? lane_q : '0;
    end
  endgenerate

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      if (xfer) begin
        m_valid_q <= 1'b1;
        m_data_q  <= pack_data_d;
        m_keep_q  <= pack_keep_d;
        m_last_q  <= (state_q == FLUSH);
      end else if (m_valid_q && m.m_ready) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        FILL: begin
          if (flush) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          // Nothing pending means the flush has nothing to close.
          if (xfer || (cnt_q == '0)) begin
            state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase

      if (pop) begin
        cnt_q <= xfer ? CW'(1) : cnt_q + CW'(1);
      end else if (xfer) begin
        cnt_q <= '0;
      end
    end
  end

  assign m.m_valid = m_valid_q;
  assign m.m_data  = m_data_q;
  assign m.m_keep  = m_keep_q;
  assign m.m_last  = m_last_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: queue-backed FWFT FIFO model feeding the
// packer, with hand-computed expected words at each step.
module tb_fifo_rd_packer;

  localparam int DW    = 8;
  localparam int BYTES = 4;

  logic          rclk;
  logic          rrst;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic          flush;
  logic          busy;

  fifo_rd_packer_if #(.DW(DW), .BYTES(BYTES)) bus ();

  fifo_rd_packer #(.DW(DW), .BYTES(BYTES)) dut (
    .rclk   (rclk),
    .rrst   (rrst),
    .rempty (rempty),
    .rdata  (rdata),
    .rinc   (rinc),
    .flush  (flush),
    .busy   (busy),
    .m      (bus.master)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic [DW-1:0]     fifo_q[$];
  logic [31:0]       rx_data[$];
  logic [3:0]        rx_keep[$];
  logic              rx_last[$];
  int                total = 0;
  int                bad   = 0;
  int                pop_cnt = 0;
  int                cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    rempty = (fifo_q.size() == 0);
    rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    refresh();
  endtask

  // One clock: sample pre-edge handshakes, take the edge, apply FIFO pop.
  task automatic step();
    logic pop_s;
    logic acc_s;
    #1;
    pop_s = rinc;
    acc_s = bus.m_valid && bus.m_ready;
    if (acc_s) begin
      rx_data.push_back(bus.m_data);
      rx_keep.push_back(bus.m_keep);
      rx_last.push_back(bus.m_last);
      $display("cycle %0d: word accepted data=%08h keep=%0h last=%0b",
               cyc, bus.m_data, bus.m_keep, bus.m_last);
    end
    @(posedge rclk);
    cyc++;
    #1;
    if (pop_s) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
    end
    flush = 1'b0;
    refresh();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rx_clear();
    rx_data.delete();
    rx_keep.delete();
    rx_last.delete();
  endtask

  task automatic chk_rx(input string tag, input int idx, input logic [31:0] d,
                        input logic [3:0] k, input logic l);
    logic [31:0] od;
    logic [3:0]  ok;
    logic        ol;
    od = (rx_data.size() > idx) ? rx_data[idx] : 'x;
    ok = (rx_keep.size() > idx) ? rx_keep[idx] : 'x;
    ol = (rx_last.size() > idx) ? rx_last[idx] : 1'bx;
    chk({tag, "_data"}, 64'(od), 64'(d));
    chk({tag, "_keep"}, 64'(ok), 64'(k));
    chk({tag, "_last"}, 64'(ol), 64'(l));
  endtask

  initial begin
    rrst        = 1'b1;
    flush       = 1'b0;
    bus.m_ready = 1'b1;
    refresh();
    steps(2);
    chk("rst_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_keep",  64'(bus.m_keep),  64'd0);
    chk("rst_data",  64'(bus.m_data),  64'd0);
    chk("rst_busy",  64'(busy),        64'd0);
    chk("rst_rinc",  64'(rinc),        64'd0);

    // 1: eight preloaded bytes stream out as two full words
    for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
    rrst = 1'b0;
    pop_cnt = 0;
    rx_clear();
    steps(4);
    chk("s1_pops4",        64'(pop_cnt),     64'd4);
    chk("s1_valid_early",  64'(bus.m_valid), 64'd0);
    step();
    chk("s1_valid_rise",   64'(bus.m_valid), 64'd1);
    chk("s1_first_data",   64'(bus.m_data),  64'h14131211);
    steps(3);
    chk("s1_pops8",        64'(pop_cnt),     64'd8);
    steps(3);
    chk("s1_pops_total",   64'(pop_cnt),     64'd8);
    chk("s1_rx_count",     64'(rx_data.size()), 64'd2);
    chk_rx("s1_w0", 0, 32'h14131211, 4'hF, 1'b0);
    chk_rx("s1_w1", 1, 32'h18171615, 4'hF, 1'b0);
    chk("s1_idle_busy",    64'(busy),        64'd0);

    // 2: two bytes then flush gives a partial last word; lane 0 restarts after
    rx_clear();
    push(8'hA1);
    push(8'hA2);
    steps(4);
    chk("s2_no_emit",      64'(bus.m_valid), 64'd0);
    chk("s2_busy",         64'(busy),        64'd1);
    flush = 1'b1;
    step();
    chk("s2_valid_pend",   64'(bus.m_valid), 64'd0);
    step();
    chk("s2_valid",        64'(bus.m_valid), 64'd1);
    chk("s2_data",         64'(bus.m_data),  64'h0000A2A1);
    chk("s2_keep",         64'(bus.m_keep),  64'h3);
    chk("s2_last",         64'(bus.m_last),  64'd1);
    for (int i = 0; i < 4; i++) push(8'(8'hB1 + i));
    steps(7);
    chk("s2_rx_count",     64'(rx_data.size()), 64'd2);
    chk_rx("s2_w0", 0, 32'h0000A2A1, 4'h3, 1'b1);
    chk_rx("s2_w1", 1, 32'hB4B3B2B1, 4'hF, 1'b0);

    // 3: backpressure holds the word and stalls pops once the accumulator is full
    rx_clear();
    bus.m_ready = 1'b0;
    pop_cnt = 0;
    for (int i = 0; i < 12; i++) push(8'(8'h21 + i));
    steps(10);
    chk("s3_held_valid",   64'(bus.m_valid), 64'd1);
    chk("s3_held_data",    64'(bus.m_data),  64'h24232221);
    chk("s3_pops_stall",   64'(pop_cnt),     64'd8);
    chk("s3_rinc_stall",   64'(rinc),        64'd0);
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    chk("s3_reload_data",  64'(bus.m_data),  64'h28272625);
    chk("s3_reload_valid", 64'(bus.m_valid), 64'd1);
    chk("s3_pop_on_xfer",  64'(pop_cnt),     64'd9);
    steps(4);
    bus.m_ready = 1'b1;
    steps(4);
    chk("s3_rx_count",     64'(rx_data.size()), 64'd3);
    chk_rx("s3_w0", 0, 32'h24232221, 4'hF, 1'b0);
    chk_rx("s3_w1", 1, 32'h28272625, 4'hF, 1'b0);
    chk_rx("s3_w2", 2, 32'h2C2B2A29, 4'hF, 1'b0);

    // 4: empty flush only raises busy for one cycle
    chk("s4_pre_busy",     64'(busy),        64'd0);
    flush = 1'b1;
    step();
    chk("s4_busy_pend",    64'(busy),        64'd1);
    chk("s4_valid_pend",   64'(bus.m_valid), 64'd0);
    step();
    chk("s4_busy_clear",   64'(busy),        64'd0);
    chk("s4_valid_none",   64'(bus.m_valid), 64'd0);

    // 5: flush on the 4th pop closes a full word with last set, no pop next edge
    bus.m_ready = 1'b0;
    pop_cnt = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    steps(3);
    flush = 1'b1;
    step();
    chk("s5_pops4",        64'(pop_cnt),     64'd4);
    chk("s5_rinc_pend",    64'(rinc),        64'd0);
    step();
    chk("s5_no_pop",       64'(pop_cnt),     64'd4);
    chk("s5_valid",        64'(bus.m_valid), 64'd1);
    chk("s5_data",         64'(bus.m_data),  64'h44332211);
    chk("s5_keep",         64'(bus.m_keep),  64'hF);
    chk("s5_last",         64'(bus.m_last),  64'd1);

    // 6: reset mid-word with a held output discards both
    push(8'h66); push(8'h77);
    steps(3);
    chk("s6_pops",         64'(pop_cnt),     64'd7);
    chk("s6_held_data",    64'(bus.m_data),  64'h44332211);
    push(8'h88);
    rrst = 1'b1;
    #1;
    chk("s6_rinc_rst",     64'(rinc),        64'd0);
    step();
    chk("s6_valid",        64'(bus.m_valid), 64'd0);
    chk("s6_keep",         64'(bus.m_keep),  64'd0);
    chk("s6_busy",         64'(busy),        64'd0);
    chk("s6_cnt",          64'(dut.cnt_q),   64'd0);
    chk("s6_no_pop_rst",   64'(pop_cnt),     64'd7);
    rx_clear();
    rrst = 1'b0;
    bus.m_ready = 1'b1;
    push(8'h89); push(8'h8A); push(8'h8B);
    steps(6);
    chk("s6_rx_count",     64'(rx_data.size()), 64'd1);
    chk_rx("s6_w0", 0, 32'h8B8A8988, 4'hF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
Read-domain stage directly downstream of the async FIFO read block. Pops bytes from the FIFO (first-word-fall-through: rdata is valid whenever rempty is low) by driving rinc. Packs BYTES consecutive bytes little-endian into one word on a valid/ready master interface, with a flush request that emits a partial word marked by a byte mask and last flag.

Parameters:
DW, 8, FIFO data width in bits (matches the FIFO rdata width).
BYTES, 4, lanes per output word; legal range 2..8.

Ports:
rclk  in  1  read-domain clock; all logic on its rising edge
rrst  in  1  reset, synchronous, active-high
rempty  in  1  FIFO empty flag (registered in the read block)
rdata  in  DW  FIFO head data, valid while rempty=0
rinc  out  1  pop strobe to the FIFO read block
flush  in  1  single-cycle request to emit the current partial word
m_valid  out  1  output word valid
m_ready  in  1  downstream accept
m_data  out  DW*BYTES  packed word; lane 0 = first popped byte in bits [DW-1:0]
m_keep  out  BYTES  lane i written
m_last  out  1  word closed by a flush
busy  out  1  cnt!=0, or m_valid, or flush pending

Behaviour:
- Reset (rrst=1 at a rclk edge) clears cnt, accumulator, flush_pend, m_valid, m_data, m_keep, and m_last to 0.
- rinc is forced to 0 while rrst=1. Reset mid-word discards the partial word and the output register, with no m_valid pulse.
- State: accumulator of BYTES lanes, lane count cnt (0..BYTES), and flush_pend (states FILL: flush_pend=0, FLUSH: flush_pend=1).
- Output register m_* is loaded only on xfer.
- Output is free when m_valid=0, or when m_valid=1 and m_ready=1.
- xfer = output free and (cnt==BYTES, or flush_pend=1 and cnt!=0).
- On xfer:
  - m_data is loaded from the accumulator, with unwritten lanes set to 0.
  - m_keep bit i is set for i<cnt.
  - m_last is set to flush_pend.
  - m_valid is set to 1.
  - cnt is cleared to 0, and flush_pend is cleared if it was set.
- When m_valid=1, m_ready=1 and there is no xfer, m_valid goes to 0. m_data, m_keep and m_last hold while m_valid=1 and m_ready=0.
- rinc = !rrst && !rempty && !flush_pend && (cnt<BYTES || xfer).
- A byte popped on the same edge as an xfer lands in lane 0, leaving cnt=1 afterwards.
- Otherwise a popped byte lands in lane cnt and cnt increments.
- Latency: the byte completing a word is popped at edge t, xfer occurs at edge t+1, and m_valid=1 after edge t+1.
- Sustained throughput is 1 byte/cycle (1 word per BYTES cycles) with m_ready held high.
- flush=1 while in FILL: flush_pend is set at that edge. A byte popped at that same edge is included in the flushed word. No pops occur while flush_pend=1.
- FLUSH with cnt==0 (no byte pending): flush_pend clears on the next edge and no word is emitted.
- FLUSH with cnt==BYTES: a full word is emitted with m_keep all ones and m_last=1.
- flush asserted while flush_pend=1 is ignored (no queuing).
- Backpressure: with m_valid=1 and m_ready=0, the accumulator fills to BYTES, then rinc=0 until the output frees. The FIFO is never popped while cnt==BYTES and there is no xfer.
- rempty=1: rinc=0 and the accumulator holds. A partial word is never emitted without flush.
- busy = (cnt!=0) || m_valid || flush_pend.

Test Plan:
1. FIFO preloaded with 0x11..0x18, m_ready=1, BYTES=4 → two words 0x14131211 then 0x18171615, m_keep=0xF, m_last=0. The first m_valid rises the cycle after the 4th pop, and rinc stays high for 8 consecutive cycles.
2. Bytes 0xA1,0xA2 popped, FIFO then empty, flush pulsed → one word m_data=0x0000A2A1, m_keep=0x3, m_last=1. The next 4 bytes form a normal word with lane 0 restarted.
3. m_ready=0 with 12 bytes available → the first word is held unchanged and the accumulator reaches cnt=4, then rinc=0. After m_ready is raised for one cycle, the held word is accepted and the next word loads on the same edge. All 12 bytes appear in order across 3 words.
4. flush pulsed with cnt=0 and rempty=1 → no m_valid. busy is high for exactly one cycle and then returns to 0.
5. flush coincident with the 4th pop → word 0x44332211 with m_keep=0xF and m_last=1. No byte is popped on the following cycle.
6. rrst asserted with cnt=3 and m_valid=1 → m_valid, m_keep, cnt and busy read 0 after the edge, and rinc is 0 during reset. After release, the first word starts from the new FIFO head in lane 0.
